div_iter_su: RTL and testbench

//  Iterative signed/unsigned integer divider for the EX stage (RV32M/RV64M DIV, DIVU, REM, REMU).

---
 rtl/div_iter_su.sv | 161 ++++++++++++++++
 tb/tb_div_iter_su.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter_su.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes and flush.
// Divide-by-zero and signed overflow resolve at accept time and skip the iteration entirely.
module div_iter_su #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic             req_rem,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] respData_q, respData_d;
    logic             negQ_q, negQ_d;
    logic             negR_q, negR_d;
    logic             remSel_q, remSel_d;

    logic             accept;
    logic             srcSign1, srcSign2;
    logic [WIDTH-1:0] srcMag1, srcMag2;
    logic [WIDTH-1:0] stepDq, stepRem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] fixQuot, fixRem;

    assign req_ready  = (state_q == IDLE) && !flush;
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_data  = respData_q;
    assign accept     = req_valid && req_ready;

    assign srcSign1 = req_signed && req_src1[WIDTH-1];
    assign srcSign2 = req_signed && req_src2[WIDTH-1];
    assign srcMag1  = srcSign1 ? -req_src1 : req_src1;
    assign srcMag2  = srcSign2 ? -req_src2 : req_src2;

    // dq_q holds the dividend bits still to be consumed in its upper part and the
    // quotient bits already produced in its lower part; both shift left together.
    always_comb begin
        stepDq  = dq_q;
        stepRem = rem_q;
        trial   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial = {stepRem, stepDq[WIDTH-1]};
            if (trial >= {1'b0, div_q}) begin
                trial  = trial - {1'b0, div_q};
                stepDq = {stepDq[WIDTH-2:0], 1'b1};
            end else begin
                stepDq = {stepDq[WIDTH-2:0], 1'b0};
            end
            stepRem = trial[WIDTH-1:0];
        end
        fixQuot = negQ_q ? -stepDq : stepDq;
        fixRem  = negR_q ? -stepRem : stepRem;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        div_d      = div_q;
        rem_d      = rem_q;
        respData_d = respData_q;
        negQ_d     = negQ_q;
        negR_d     = negR_q;
        remSel_d   = remSel_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    remSel_d = req_rem;
                    if (req_src2 == '0) begin
                        respData_d = req_rem ? req_src1 : '1;
                        state_d    = DONE;
                    end else if (req_signed && (req_src1 == MIN_VAL) && (req_src2 == '1)) begin
                        respData_d = req_rem ? '0 : MIN_VAL;
                        state_d    = DONE;
                    end else begin
                        dq_d    = srcMag1;
                        div_d   = srcMag2;
                        rem_d   = '0;
                        cnt_d   = '0;
                        negQ_d  = srcSign1 ^ srcSign2;
                        negR_d  = srcSign1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dq_d  = stepDq;
                rem_d = stepRem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    respData_d = remSel_q ? fixRem : fixQuot;
                    cnt_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dq_q       <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            respData_q <= '0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            remSel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            respData_q <= respData_d;
            negQ_q     <= negQ_d;
            negR_q     <= negR_d;
            remSel_q   <= remSel_d;
        end
    end

endmodule

// File: tb/tb_div_iter_su.sv
// Directed bench for div_iter_su: a 32-bit one-bit-per-cycle instance and a 64-bit
// four-bits-per-cycle instance, with hand-computed quotients, remainders and latencies.
module tb_div_iter_su;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        reqSigned = 1'b0;
    logic        reqRem = 1'b0;
    logic [63:0] reqSrc1 = '0;
    logic [63:0] reqSrc2 = '0;
    logic        flush = 1'b0;
    logic        respReady = 1'b0;

    logic        sReqValid = 1'b0;
    logic        sReqReady, sRespValid, sBusy;
    logic [31:0] sRespData;
    logic        wReqValid = 1'b0;
    logic        wReqReady, wRespValid, wBusy;
    logic [63:0] wRespData;

    int vecCount = 0;
    int missCount = 0;

    always #5 cpu_clk = ~cpu_clk;

    div_iter_su #(.WIDTH(32), .BITS_PER_CYCLE(1)) dutSmall (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .req_valid (sReqValid),
        .req_ready (sReqReady),
        .req_signed(reqSigned),
        .req_rem   (reqRem),
        .req_src1  (reqSrc1[31:0]),
        .req_src2  (reqSrc2[31:0]),
        .flush     (flush),
        .resp_valid(sRespValid),
        .resp_ready(respReady),
        .resp_data (sRespData),
        .busy      (sBusy)
    );

    div_iter_su #(.WIDTH(64), .BITS_PER_CYCLE(4)) dutWide (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .req_valid (wReqValid),
        .req_ready (wReqReady),
        .req_signed(reqSigned),
        .req_rem   (reqRem),
        .req_src1  (reqSrc1),
        .req_src2  (reqSrc2),
        .flush     (flush),
        .resp_valid(wRespValid),
        .resp_ready(respReady),
        .resp_data (wRespData),
        .busy      (wBusy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Latency counts rising edges after the accepting edge until resp_valid is seen;
    // hold keeps resp_ready low for that many extra cycles before retiring.
    task automatic applyStimulus(input string tag, input bit wide, input bit sgn, input bit rem,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input int expLat, input logic [63:0] expData, input int hold);
        int lat;
        bit seen;
        logic [63:0] heldData;
        checkOutput({tag, ".ready"}, 64'(wide ? wReqReady : sReqReady), 64'd1);
        reqSigned = sgn;
        reqRem    = rem;
        reqSrc1   = a;
        reqSrc2   = b;
        if (wide) wReqValid = 1'b1;
        else      sReqValid = 1'b1;
        @(posedge cpu_clk); #1;
        sReqValid = 1'b0;
        wReqValid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            if (wide ? wRespValid : sRespValid) seen = 1'b1;
            else begin
                @(posedge cpu_clk); #1;
                lat++;
            end
        end
        checkOutput({tag, ".lat"}, 64'(lat), 64'(expLat));
        heldData = wide ? wRespData : {32'b0, sRespData};
        checkOutput({tag, ".data"}, heldData, expData);
        for (int i = 0; i < hold; i++) begin
            @(posedge cpu_clk); #1;
            checkOutput({tag, ".holdValid"}, 64'(wide ? wRespValid : sRespValid), 64'd1);
            checkOutput({tag, ".holdData"}, wide ? wRespData : {32'b0, sRespData}, expData);
            checkOutput({tag, ".holdReady"}, 64'(wide ? wReqReady : sReqReady), 64'd0);
        end
        respReady = 1'b1;
        @(posedge cpu_clk); #1;
        respReady = 1'b0;
        checkOutput({tag, ".retire"}, 64'(wide ? wRespValid : sRespValid), 64'd0);
        checkOutput({tag, ".idle"}, 64'(wide ? wReqReady : sReqReady), 64'd1);
    endtask

    initial begin
        #12;
        checkOutput("rst.valid", 64'(sRespValid), 64'd0);
        checkOutput("rst.busy", 64'(sBusy), 64'd0);
        checkOutput("rst.data", 64'(sRespData), 64'd0);
        cpu_rstn = 1'b1;
        @(posedge cpu_clk); #1;
        checkOutput("rst.ready", 64'(sReqReady), 64'd1);

        applyStimulus("divu100_7", 0, 0, 0, 64'd100, 64'd7, 32, 64'd14, 0);
        applyStimulus("remu100_7", 0, 0, 1, 64'd100, 64'd7, 32, 64'd2, 0);
        applyStimulus("div-7_2", 0, 1, 0, 64'hFFFFFFF9, 64'd2, 32, 64'hFFFFFFFD, 0);
        applyStimulus("rem-7_2", 0, 1, 1, 64'hFFFFFFF9, 64'd2, 32, 64'hFFFFFFFF, 0);
        applyStimulus("rem7_-2", 0, 1, 1, 64'd7, 64'hFFFFFFFE, 32, 64'd1, 0);
        applyStimulus("divu_by0", 0, 0, 0, 64'h1234, 64'd0, 0, 64'hFFFFFFFF, 0);
        applyStimulus("remu_by0", 0, 0, 1, 64'h1234, 64'd0, 0, 64'h1234, 0);
        applyStimulus("div_ovf", 0, 1, 0, 64'h80000000, 64'hFFFFFFFF, 0, 64'h80000000, 0);
        applyStimulus("rem_ovf", 0, 1, 1, 64'h80000000, 64'hFFFFFFFF, 0, 64'd0, 0);
        applyStimulus("divu_msb", 0, 0, 0, 64'h80000000, 64'hFFFFFFFF, 32, 64'd0, 0);
        applyStimulus("remu_msb", 0, 0, 1, 64'h80000000, 64'hFFFFFFFF, 32, 64'h80000000, 0);
        applyStimulus("remu_small", 0, 0, 1, 64'd5, 64'd9, 32, 64'd5, 0);
        applyStimulus("backpress", 0, 0, 0, 64'd1000, 64'd10, 32, 64'd100, 5);

        // Flush while the 32-bit unit sits at cnt==10 and a new request is waiting.
        reqSigned = 1'b0; reqRem = 1'b0; reqSrc1 = 64'd1000; reqSrc2 = 64'd3;
        sReqValid = 1'b1;
        @(posedge cpu_clk); #1;
        sReqValid = 1'b0;
        repeat (10) begin
            @(posedge cpu_clk); #1;
        end
        checkOutput("flush.busyBefore", 64'(sBusy), 64'd1);
        flush = 1'b1;
        sReqValid = 1'b1;
        reqSrc1 = 64'd77;
        #1;
        checkOutput("flush.reqReady", 64'(sReqReady), 64'd0);
        @(posedge cpu_clk); #1;
        flush = 1'b0;
        sReqValid = 1'b0;
        checkOutput("flush.busyAfter", 64'(sBusy), 64'd0);
        checkOutput("flush.noResp", 64'(sRespValid), 64'd0);
        repeat (40) begin
            @(posedge cpu_clk); #1;
        end
        checkOutput("flush.stillIdle", 64'(sBusy), 64'd0);
        checkOutput("flush.neverValid", 64'(sRespValid), 64'd0);
        applyStimulus("divu_allones_3", 0, 0, 0, 64'hFFFFFFFF, 64'd3, 32, 64'h55555555, 0);

        applyStimulus("w.divu", 1, 0, 0, 64'hFFFFFFFFFFFFFFFF, 64'h10, 16, 64'h0FFFFFFFFFFFFFFF, 0);
        applyStimulus("w.remu", 1, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'h10, 16, 64'hF, 0);
        applyStimulus("w.div-100_7", 1, 1, 0, 64'hFFFFFFFFFFFFFF9C, 64'd7, 16, 64'hFFFFFFFFFFFFFFF2, 0);
        applyStimulus("w.rem-100_7", 1, 1, 1, 64'hFFFFFFFFFFFFFF9C, 64'd7, 16, 64'hFFFFFFFFFFFFFFFE, 0);
        applyStimulus("w.div2p32_-2", 1, 1, 0, 64'h0000000100000000, 64'hFFFFFFFFFFFFFFFE, 16, 64'hFFFFFFFF80000000, 0);
        applyStimulus("w.rem-53_16", 1, 1, 1, 64'hFFFFFFFFFFFFFFCB, 64'd16, 16, 64'hFFFFFFFFFFFFFFFB, 0);
        applyStimulus("w.div_ovf", 1, 1, 0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 0, 64'h8000000000000000, 0);

        // Reset pulse in the middle of a 64-bit calculation.
        reqSigned = 1'b0; reqRem = 1'b0; reqSrc1 = 64'd999; reqSrc2 = 64'd4;
        wReqValid = 1'b1;
        @(posedge cpu_clk); #1;
        wReqValid = 1'b0;
        repeat (5) begin
            @(posedge cpu_clk); #1;
        end
        checkOutput("w.rstBusyBefore", 64'(wBusy), 64'd1);
        cpu_rstn = 1'b0;
        #1;
        checkOutput("w.rstBusy", 64'(wBusy), 64'd0);
        checkOutput("w.rstValid", 64'(wRespValid), 64'd0);
        checkOutput("w.rstData", wRespData, 64'd0);
        @(posedge cpu_clk); #1;
        cpu_rstn = 1'b1;
        @(posedge cpu_clk); #1;
        checkOutput("w.rstReady", 64'(wReqReady), 64'd1);
        applyStimulus("w.afterRst", 1, 0, 0, 64'd999, 64'd4, 16, 64'd249, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
